nx_node_store_arbiter: RTL and testbench

Shares the node's single-port store RAM between several requesters. Typical requesters are the message decoder, which loads instructions and output mappings, the output message controller, and the core instruction fetch. The block runs round-robin arbitration with optional burst locking, drives the RAM port combinationally from the winner, and returns read data one cycle later. Each requester has its own data holding register, so data stays stable while that requester is stalled. It sits between the node control sub-blocks and the store RAM.

---
 rtl/nx_node_store_arbiter_pkg.sv | 13 +
 rtl/nx_rr_arbiter.sv | 29 ++
 rtl/nx_node_store_arbiter.sv | 135 +++++++++++++
 tb/tb_nx_node_store_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nx_node_store_arbiter_pkg.sv
// Shared constants and helpers for the node store arbiter
// and its round-robin grant encoder.
package nx_node_store_arbiter_pkg;

  localparam int NX_REQUESTERS = 3;
  localparam int NX_RAM_ADDR_W = 10;
  localparam int NX_RAM_DATA_W = 32;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nx_rr_arbiter.sv
// Combinational rotate-priority encoder: first request at or
// above the pointer wins, wrapping modulo WIDTH.
module nx_rr_arbiter
  import nx_node_store_arbiter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0]        i_req,
  input  logic [ptr_w(WIDTH)-1:0] i_ptr,
  output logic [WIDTH-1:0]        o_grant
);

  int idx;

  // Scan from the farthest offset down so the nearest wins.
  always_comb begin
    o_grant = '0;
    idx     = 0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      idx = int'(i_ptr) + k;
      if (idx >= WIDTH) idx = idx - WIDTH;
      if (idx < WIDTH && i_req[idx]) begin
        o_grant      = '0;
        o_grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nx_node_store_arbiter.sv
// Round-robin arbiter with burst lock sharing the single-port
// store RAM; per-requester read data holding registers.
module nx_node_store_arbiter
  import nx_node_store_arbiter_pkg::*;
#(
  parameter int REQUESTERS = NX_REQUESTERS,
  parameter int RAM_ADDR_W = NX_RAM_ADDR_W,
  parameter int RAM_DATA_W = NX_RAM_DATA_W
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  output logic                             o_idle,
  input  logic [REQUESTERS*RAM_ADDR_W-1:0] i_req_addr,
  input  logic [REQUESTERS*RAM_DATA_W-1:0] i_req_wr_data,
  input  logic [REQUESTERS-1:0]            i_req_wr_en,
  input  logic [REQUESTERS-1:0]            i_req_rd_en,
  input  logic [REQUESTERS-1:0]            i_req_lock,
  output logic [REQUESTERS-1:0]            o_req_grant,
  output logic [REQUESTERS*RAM_DATA_W-1:0] o_req_rd_data,
  output logic [REQUESTERS-1:0]            o_req_rd_valid,
  output logic [RAM_ADDR_W-1:0]            o_ram_addr,
  output logic [RAM_DATA_W-1:0]            o_ram_wr_data,
  output logic                             o_ram_wr_en,
  output logic                             o_ram_rd_en,
  input  logic [RAM_DATA_W-1:0]            i_ram_rd_data
);

  localparam int PW = ptr_w(REQUESTERS);

  logic [RAM_ADDR_W-1:0] addr_s  [REQUESTERS];
  logic [RAM_DATA_W-1:0] wdata_s [REQUESTERS];
  logic [RAM_DATA_W-1:0] hold_q  [REQUESTERS];

  logic [REQUESTERS-1:0] req;
  logic [REQUESTERS-1:0] gnt_rr;
  logic [REQUESTERS-1:0] gnt;
  logic [REQUESTERS-1:0] rd_vld;
  logic [PW-1:0]         gidx;
  logic                  gnt_any;

  logic [PW-1:0]         ptr_q;
  logic                  lock_vld_q;
  logic [PW-1:0]         lock_idx_q;
  logic                  rd_pend_q;
  logic [PW-1:0]         rd_idx_q;
  logic [RAM_ADDR_W-1:0] addr_q;
  logic [RAM_DATA_W-1:0] wdata_q;

  for (genvar n = 0; n < REQUESTERS; n++) begin : g_slice
    assign addr_s[n]  = i_req_addr[n*RAM_ADDR_W +: RAM_ADDR_W];
    assign wdata_s[n] = i_req_wr_data[n*RAM_DATA_W +: RAM_DATA_W];
    assign o_req_rd_data[n*RAM_DATA_W +: RAM_DATA_W] =
      o_req_rd_valid[n] ? i_ram_rd_data : hold_q[n];
  end

  assign req = i_req_rd_en | i_req_wr_en;

  nx_rr_arbiter #(
    .WIDTH (REQUESTERS)
  ) u_rr (
    .i_req   (req),
    .i_ptr   (ptr_q),
    .o_grant (gnt_rr)
  );

  // A live lock owner pre-empts the round-robin choice.
  always_comb begin
    gnt = gnt_rr;
    if (lock_vld_q && req[lock_idx_q]) begin
      gnt             = '0;
      gnt[lock_idx_q] = 1'b1;
    end
  end

  always_comb begin
    gidx = '0;
    for (int n = 0; n < REQUESTERS; n++) begin
      if (gnt[n]) gidx = PW'(n);
    end
  end

  assign gnt_any       = |gnt;
  assign o_req_grant   = gnt;
  assign o_ram_wr_en   = gnt_any & i_req_wr_en[gidx];
  assign o_ram_rd_en   = gnt_any & i_req_rd_en[gidx] & ~i_req_wr_en[gidx];
  assign o_ram_addr    = gnt_any ? addr_s[gidx]  : addr_q;
  assign o_ram_wr_data = gnt_any ? wdata_s[gidx] : wdata_q;

  assign o_idle = ~(|req) & ~rd_pend_q;

  always_comb begin
    rd_vld = '0;
    if (rd_pend_q) rd_vld[rd_idx_q] = 1'b1;
  end

  // Gate with reset so a read in flight is dropped immediately.
  assign o_req_rd_valid = i_rst ? rd_vld : '0;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      ptr_q      <= '0;
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_idx_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      rd_pend_q <= o_ram_rd_en;
      rd_idx_q  <= gidx;
      if (gnt_any) begin
        addr_q  <= addr_s[gidx];
        wdata_q <= wdata_s[gidx];
        if (i_req_lock[gidx]) begin
          lock_vld_q <= 1'b1;
          lock_idx_q <= gidx;
        end else begin
          lock_vld_q <= 1'b0;
          if (gidx == PW'(REQUESTERS - 1)) ptr_q <= '0;
          else                             ptr_q <= gidx + 1'b1;
        end
      end else begin
        lock_vld_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int n = 0; n < REQUESTERS; n++) begin
      if (!i_rst)         hold_q[n] <= '0;
      else if (rd_vld[n]) hold_q[n] <= i_ram_rd_data;
    end
  end

endmodule

// File: tb/tb_nx_node_store_arbiter.sv
// Directed bench for nx_node_store_arbiter with a behavioural
// one-cycle-latency store RAM.
module tb_nx_node_store_arbiter;

  localparam int R  = 3;
  localparam int AW = 10;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic            idle;
  logic [R*AW-1:0] req_addr;
  logic [R*DW-1:0] req_wr_data;
  logic [R-1:0]    req_wr_en;
  logic [R-1:0]    req_rd_en;
  logic [R-1:0]    req_lock;
  logic [R-1:0]    grant;
  logic [R*DW-1:0] rd_data;
  logic [R-1:0]    rd_valid;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wr_data;
  logic            ram_wr_en;
  logic            ram_rd_en;
  logic [DW-1:0]   ram_rd_data;

  int n_assert = 0;
  int n_fail   = 0;

  nx_node_store_arbiter #(
    .REQUESTERS (R),
    .RAM_ADDR_W (AW),
    .RAM_DATA_W (DW)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .o_idle         (idle),
    .i_req_addr     (req_addr),
    .i_req_wr_data  (req_wr_data),
    .i_req_wr_en    (req_wr_en),
    .i_req_rd_en    (req_rd_en),
    .i_req_lock     (req_lock),
    .o_req_grant    (grant),
    .o_req_rd_data  (rd_data),
    .o_req_rd_valid (rd_valid),
    .o_ram_addr     (ram_addr),
    .o_ram_wr_data  (ram_wr_data),
    .o_ram_wr_en    (ram_wr_en),
    .o_ram_rd_en    (ram_rd_en),
    .i_ram_rd_data  (ram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
    case (a)
      10'h010: return 32'hDEADBEEF;
      10'h020: return 32'h11111111;
      10'h021: return 32'h22222222;
      10'h022: return 32'h33333333;
      10'h040: return 32'hA5A5A5A5;
      10'h041: return 32'h5A5A5A5A;
      default: return 32'hC0DE0000 | {22'h0, a};
    endcase
  endfunction

  logic [AW-1:0] rd_addr_q;
  logic [AW-1:0] wr_addr_seen;
  logic [DW-1:0] wr_data_seen;

  always @(posedge clk) begin
    rd_addr_q <= ram_addr;
    if (ram_wr_en) begin
      wr_addr_seen <= ram_addr;
      wr_data_seen <= ram_wr_data;
    end
  end

  assign ram_rd_data = ram_val(rd_addr_q);

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    req_addr    = '0;
    req_wr_data = '0;
    req_wr_en   = '0;
    req_rd_en   = '0;
    req_lock    = '0;
  endtask

  task automatic drv(input int n, input logic rd, input logic wr,
                     input logic lk, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    req_rd_en[n]             = rd;
    req_wr_en[n]             = wr;
    req_lock[n]              = lk;
    req_addr[n*AW +: AW]     = a;
    req_wr_data[n*DW +: DW]  = d;
  endtask

  function automatic logic [DW-1:0] dat(input int n);
    return rd_data[n*DW +: DW];
  endfunction

  logic [R-1:0] rr_exp [4];

  initial begin
    rr_exp[0] = 3'b001;
    rr_exp[1] = 3'b010;
    rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001;

    rst = 1'b0;
    clr();
    tick();
    tick();
    chk("rst_rd_valid", rd_valid, 3'b000);
    chk("rst_rd_data", rd_data, '0);
    rst = 1'b1;
    #1;
    chk("rst_idle", idle, 1'b1);
    chk("rst_grant", grant, 3'b000);
    chk("rst_ram_en", {ram_wr_en, ram_rd_en}, 2'b00);

    // single reader
    drv(0, 1'b1, 1'b0, 1'b0, 10'h010, 32'h0);
    #1;
    chk("single_grant", grant, 3'b001);
    chk("single_addr", ram_addr, 10'h010);
    chk("single_rd_en", ram_rd_en, 1'b1);
    tick();
    clr();
    #1;
    chk("single_valid", rd_valid, 3'b001);
    chk("single_data", dat(0), 32'hDEADBEEF);
    chk("single_busy", idle, 1'b0);
    tick();
    chk("single_valid_drop", rd_valid, 3'b000);
    chk("single_data_hold", dat(0), 32'hDEADBEEF);
    chk("single_idle", idle, 1'b1);

    // round robin from pointer 0
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int n = 0; n < R; n++)
      drv(n, 1'b1, 1'b0, 1'b0, AW'(10'h020 + n), 32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_grant%0d", k), grant, rr_exp[k]);
      if (k > 0) begin
        chk($sformatf("rr_valid%0d", k), rd_valid, rr_exp[k-1]);
      end
      tick();
    end
    clr();
    #1;
    chk("rr_valid4", rd_valid, 3'b001);
    chk("rr_data0", dat(0), 32'h11111111);
    chk("rr_data1", dat(1), 32'h22222222);
    chk("rr_data2", dat(2), 32'h33333333);
    tick();

    // lock burst by requester 1 (pointer now 1)
    drv(0, 1'b1, 1'b0, 1'b0, 10'h050, 32'h0);
    drv(2, 1'b1, 1'b0, 1'b0, 10'h052, 32'h0);
    for (int k = 0; k < 4; k++) begin
      drv(1, 1'b1, 1'b0, 1'b1, AW'(10'h030 + k), 32'h0);
      #1;
      chk($sformatf("lock_grant%0d", k), grant, 3'b010);
      tick();
    end
    drv(1, 1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
    #1;
    chk("lock_after_grant", grant, 3'b100);
    chk("lock_last_valid", rd_valid, 3'b010);
    chk("lock_last_data", dat(1), 32'hC0DE0033);
    tick();
    #1;
    chk("lock_then_req0", grant, 3'b001);
    chk("lock_req2_data", dat(2), 32'hC0DE0052);
    tick();
    clr();
    #1;
    chk("lock_req0_data", dat(0), 32'hC0DE0050);
    tick();

    // write and read together by requester 2
    drv(2, 1'b1, 1'b1, 1'b0, 10'h3FF, 32'h12345678);
    #1;
    chk("coll_grant", grant, 3'b100);
    chk("coll_en", {ram_wr_en, ram_rd_en}, 2'b10);
    chk("coll_addr", ram_addr, 10'h3FF);
    chk("coll_wdata", ram_wr_data, 32'h12345678);
    tick();
    clr();
    #1;
    chk("coll_no_valid", rd_valid, 3'b000);
    chk("coll_ram_write", {wr_addr_seen, wr_data_seen},
        {10'h3FF, 32'h12345678});
    chk("idle_addr_hold", ram_addr, 10'h3FF);
    chk("idle_wdata_hold", ram_wr_data, 32'h12345678);
    chk("coll_idle", idle, 1'b1);
    tick();

    // data hold while other requesters are served (pointer 0)
    drv(0, 1'b1, 1'b0, 1'b0, 10'h040, 32'h0);
    #1;
    chk("hold_grant0", grant, 3'b001);
    tick();
    clr();
    drv(1, 1'b1, 1'b0, 1'b0, 10'h041, 32'h0);
    #1;
    chk("hold_grant1", grant, 3'b010);
    chk("hold_valid0", rd_valid, 3'b001);
    chk("hold_data0", dat(0), 32'hA5A5A5A5);
    tick();
    clr();
    #1;
    chk("hold_valid1", rd_valid, 3'b010);
    chk("hold_data1", dat(1), 32'h5A5A5A5A);
    chk("hold_data0_kept", dat(0), 32'hA5A5A5A5);
    chk("hold_data2_kept", dat(2), 32'hC0DE0052);
    tick();
    chk("hold_data1_kept", dat(1), 32'h5A5A5A5A);

    // reset with a locked read in flight (pointer 2)
    drv(2, 1'b1, 1'b0, 1'b1, 10'h060, 32'h0);
    #1;
    chk("mid_grant", grant, 3'b100);
    tick();
    clr();
    rst = 1'b0;
    #1;
    chk("mid_valid_in_rst", rd_valid, 3'b000);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_valid_after", rd_valid, 3'b000);
    chk("mid_idle", idle, 1'b1);
    chk("mid_data2_cleared", dat(2), 32'h0);
    drv(1, 1'b1, 1'b0, 1'b0, 10'h070, 32'h0);
    drv(2, 1'b1, 1'b0, 1'b0, 10'h072, 32'h0);
    #1;
    chk("mid_ptr_lock_clear", grant, 3'b010);
    tick();
    clr();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
